// File: rtl/lifo_arb_pkg.sv
// Shared types for the LIFO stack arbiter: opcodes, FSM states, default data width.
package lifo_arb_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // An op is refused up front so it never strobes the stack.
    function automatic logic op_refused(op_t op, logic empty, logic full);
        return (op == OP_NONE) || (op == OP_PUSH && full) ||
               ((op == OP_POP || op == OP_PEEK) && empty);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      ptr_nxt_o
);

    always_comb begin
        logic found;
        int   idx;
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = PW'((idx + 1) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/lifo_stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack among NUM_REQ requesters.
// Each op walks IDLE -> ISSUE -> WAIT -> RESP; refused ops go IDLE -> RESP.
module lifo_stack_arbiter
    import lifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 8
) (
    input  logic                       Clk_In,
    input  logic                       Reset_In,
    input  logic [NUM_REQ-1:0]         Req_In,
    input  logic [2*NUM_REQ-1:0]       Op_In,
    input  logic [DATA_W*NUM_REQ-1:0]  Wr_Data_In,
    output logic [NUM_REQ-1:0]         Grant_Out,
    output logic [NUM_REQ-1:0]         Done_Out,
    output logic [DATA_W-1:0]          Rd_Data_Out,
    output logic                       Err_Out,
    output logic                       Busy_Out,
    output logic [$clog2(DEPTH+1)-1:0] Count_Out,
    output logic [DATA_W-1:0]          Stk_Data_Out,
    output logic                       Stk_Push_Out,
    output logic                       Stk_Pop_Out,
    output logic                       Stk_Peek_Out,
    input  logic [DATA_W-1:0]          Stk_Data_In,
    input  logic                       Stk_Empty_In,
    input  logic                       Stk_Full_In
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    state_t              state_q;
    op_t                 op_q;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, done_q, win_d;
    logic [DATA_W-1:0]   rd_q, sdat_q, wdat_d;
    logic                err_q, busy_q, push_q, pop_q, peek_q;
    logic [CW-1:0]       cnt_q;
    op_t                 op_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .req_i     (Req_In),
        .ptr_i     (ptr_q),
        .gnt_o     (win_d),
        .ptr_nxt_o (ptr_d)
    );

    always_comb begin
        op_d   = OP_NONE;
        wdat_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_d[i]) begin
                op_d   = op_t'(Op_In[2*i +: 2]);
                wdat_d = Wr_Data_In[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rd_q    <= '0;
            sdat_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            peek_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (|win_d) begin
                    gnt_q  <= win_d;
                    ptr_q  <= ptr_d;
                    op_q   <= op_d;
                    sdat_q <= wdat_d;
                    busy_q <= 1'b1;
                    if (op_refused(op_d, Stk_Empty_In, Stk_Full_In)) begin
                        state_q <= RESP;
                        done_q  <= win_d;
                        err_q   <= 1'b1;
                        rd_q    <= '0;
                    end else begin
                        state_q <= ISSUE;
                        push_q  <= (op_d == OP_PUSH);
                        pop_q   <= (op_d == OP_POP);
                        peek_q  <= (op_d == OP_PEEK);
                    end
                end
                ISSUE: begin
                    push_q  <= 1'b0;
                    pop_q   <= 1'b0;
                    peek_q  <= 1'b0;
                    state_q <= WAIT;
                    if (op_q == OP_PUSH) cnt_q <= cnt_q + CW'(1);
                    if (op_q == OP_POP)  cnt_q <= cnt_q - CW'(1);
                end
                WAIT: begin
                    // Stack Data_Out became valid this cycle, one edge after the strobe.
                    rd_q    <= (op_q == OP_PUSH) ? '0 : Stk_Data_In;
                    done_q  <= gnt_q;
                    err_q   <= 1'b0;
                    state_q <= RESP;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    err_q   <= 1'b0;
                    rd_q    <= '0;
                    sdat_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Grant_Out    = gnt_q;
    assign Done_Out     = done_q;
    assign Rd_Data_Out  = rd_q;
    assign Err_Out      = err_q;
    assign Busy_Out     = busy_q;
    assign Count_Out    = cnt_q;
    assign Stk_Data_Out = sdat_q;
    assign Stk_Push_Out = push_q;
    assign Stk_Pop_Out  = pop_q;
    assign Stk_Peek_Out = peek_q;

endmodule

// File: tb/tb_lifo_stack_arbiter.sv
// Bench for lifo_stack_arbiter: behavioural stack on the far side, queue-based
// reference stack and round-robin pointer checked at every Done pulse.
module tb_lifo_stack_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [2*N-1:0]    op;
    logic [DW*N-1:0]   wd;
    logic [N-1:0]      gnt, done;
    logic [DW-1:0]     rd, sdo, s_do;
    logic              err, busy, spush, spop, speek;
    logic [CW-1:0]     cnt;
    logic              s_empty = 1'b1, s_full = 1'b0;

    always #5 clk = ~clk;

    lifo_stack_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .Clk_In       (clk),
        .Reset_In     (rst),
        .Req_In       (req),
        .Op_In        (op),
        .Wr_Data_In   (wd),
        .Grant_Out    (gnt),
        .Done_Out     (done),
        .Rd_Data_Out  (rd),
        .Err_Out      (err),
        .Busy_Out     (busy),
        .Count_Out    (cnt),
        .Stk_Data_Out (sdo),
        .Stk_Push_Out (spush),
        .Stk_Pop_Out  (spop),
        .Stk_Peek_Out (speek),
        .Stk_Data_In  (s_do),
        .Stk_Empty_In (s_empty),
        .Stk_Full_In  (s_full)
    );

    // Stack on the far side of the arbiter: registered data and flags.
    logic [DW-1:0] sq[$];
    always @(posedge clk) begin
        if (rst) begin
            sq.delete();
            s_do <= '0;
        end else if (spush && sq.size() < DEPTH) begin
            sq.push_back(sdo);
        end else if (spop && sq.size() > 0) begin
            s_do <= sq.pop_back();
        end else if (speek && sq.size() > 0) begin
            s_do <= sq[$];
        end
        s_empty <= (sq.size() == 0);
        s_full  <= (sq.size() == DEPTH);
    end

    // Reference model: contents of the shared stack and the round-robin pointer.
    logic [DW-1:0] mstk[$];
    int            mptr;
    logic [1:0]    qop[N][$];
    logic [DW-1:0] qdat[N][$];
    int            n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add(input int r, input logic [1:0] o, input logic [DW-1:0] d);
        qop[r].push_back(o);
        qdat[r].push_back(d);
    endtask

    task automatic run(input int budget);
        int            cyc = 0, gcyc = 0, npush = 0, npop = 0, npeek = 0;
        int            w, ew, idx;
        logic [DW-1:0] pdat = '0, erd;
        logic [1:0]    o;
        logic          refuse;
        for (int i = 0; i < N; i++) begin
            if (qop[i].size() > 0) begin
                req[i]          = 1'b1;
                op[2*i +: 2]    = qop[i][0];
                wd[DW*i +: DW]  = qdat[i][0];
            end
        end
        while (req != '0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (spush) begin npush++; pdat = sdo; end
            if (spop)  npop++;
            if (speek) npeek++;
            if (|gnt)  gcyc++;
            if (|done) begin
                w = 0;
                for (int i = 0; i < N; i++) if (done[i]) w = i;
                ew = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (mptr + k) % N;
                    if (ew < 0 && req[idx]) ew = idx;
                end
                chk("winner", w, ew);
                chk("grant_vs_done", gnt, done);
                o      = qop[w][0];
                refuse = (o == 2'b00) || (o == 2'b01 && mstk.size() == DEPTH) ||
                         (o[1] && mstk.size() == 0);
                erd = '0;
                if (!refuse) begin
                    case (o)
                        2'b01:   mstk.push_back(qdat[w][0]);
                        2'b10:   erd = mstk.pop_back();
                        default: erd = mstk[$];
                    endcase
                end
                chk("err", err, refuse);
                chk("rd_data", rd, erd);
                chk("grant_cycles", gcyc, refuse ? 1 : 3);
                chk("push_pulses", npush, (!refuse && o == 2'b01) ? 1 : 0);
                chk("pop_pulses", npop, (!refuse && o == 2'b10) ? 1 : 0);
                chk("peek_pulses", npeek, (!refuse && o == 2'b11) ? 1 : 0);
                if (!refuse && o == 2'b01) chk("push_data", pdat, qdat[w][0]);
                chk("count", cnt, mstk.size());
                chk("busy", busy, 1);
                mptr = (w + 1) % N;
                void'(qop[w].pop_front());
                void'(qdat[w].pop_front());
                if (qop[w].size() > 0) begin
                    op[2*w +: 2]   = qop[w][0];
                    wd[DW*w +: DW] = qdat[w][0];
                end else begin
                    req[w] = 1'b0;
                end
                gcyc = 0; npush = 0; npop = 0; npeek = 0;
            end
        end
        if (req != '0) begin
            chk("timeout", 0, 1);
            req = '0;
            for (int i = 0; i < N; i++) begin qop[i].delete(); qdat[i].delete(); end
        end
        @(negedge clk);
        chk("idle_grant", gnt, 0);
        chk("idle_busy", busy, 0);
        chk("idle_stk_data", sdo, 0);
    endtask

    initial begin
        logic hit, dseen;
        int   x;
        rst = 1'b1; req = '0; op = '0; wd = '0; mptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {gnt, done, rd, err, busy, cnt, sdo, spush, spop, speek}, 0);
        rst = 1'b0;

        add(0, 2'b10, 8'h00);                          // pop on empty
        run(50);
        add(1, 2'b01, 8'hA5);
        run(50);
        add(2, 2'b11, 8'h00); add(2, 2'b10, 8'h00);    // peek then pop
        run(50);
        chk("empty_after_pop", s_empty, 1);
        add(0, 2'b01, 8'h11); add(1, 2'b01, 8'h22);
        add(2, 2'b01, 8'h33); add(3, 2'b01, 8'h44);
        run(100);
        for (int i = 0; i < 4; i++) add(0, 2'b10, 8'h00);
        run(100);
        for (int i = 1; i <= 8; i++) add(0, 2'b01, 8'(i));
        add(0, 2'b01, 8'hFF); add(0, 2'b10, 8'h00);    // overflow then pop
        run(200);
        add(0, 2'b11, 8'h00); add(0, 2'b11, 8'h00);
        add(3, 2'b11, 8'h00); add(3, 2'b11, 8'h00);
        run(100);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 3)) begin
                        x = $urandom_range(0, 9);
                        add(i, (x < 4) ? 2'b01 : (x < 7) ? 2'b10 : (x < 9) ? 2'b11 : 2'b00,
                            8'($urandom));
                    end
                end
            end
            run(500);
        end

        // Reset while a push is on the stack strobe.
        req[0] = 1'b1; op[1:0] = 2'b01; wd[7:0] = 8'h5A;
        hit = 1'b0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            hit = spush;
        end
        chk("t6_push_seen", hit, 1);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("t6_reset_outputs", {gnt, done, rd, err, busy, cnt, sdo, spush, spop, speek}, 0);
        rst = 1'b0;
        dseen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            dseen = dseen | (|done) | spush;
        end
        chk("t6_no_done", dseen, 0);
        mstk.delete();
        mptr = 0;
        add(1, 2'b10, 8'h00);
        run(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
